// File: rtl/mcycle85.sv
// Machine-cycle / T-state sequencer for the my1core85 core.
// Steps M1..M5 and T1..T6 with READY wait states, bus HOLD between cycles and halt.
`timescale 1ns/1ps

module mcycle85 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inRDY,
    input  logic       inHLD,
    input  logic [2:0] inMC,
    input  logic       inT6,
    input  logic       inHLT,
    output logic [2:0] outT,
    output logic [2:0] outM,
    output logic       outALE,
    output logic       outFET,
    output logic       outLST,
    output logic       outHLDA,
    output logic       outHLT
);

    localparam int unsigned MC_W  = 3;
    localparam int unsigned MC_MAX = 5;

    typedef enum logic [3:0] {
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_THLT,
        ST_THLD
    } state_e;

    state_e          state_q, state_d;
    logic [MC_W-1:0] mc_q, mc_d;
    logic [MC_W-1:0] cnt_q, cnt_d;
    logic            six_q, six_d;
    logic            halted_q, halted_d;
    logic            hpend_q, hpend_d;

    logic [2:0]      t_q, t_d;
    logic [2:0]      m_q, m_d;
    logic            ale_q, ale_d;
    logic            fet_q, fet_d;
    logic            lst_q, lst_d;
    logic            hlda_q, hlda_d;
    logic            hlt_q, hlt_d;

    logic            end_mc;
    logic            end_state;
    logic [MC_W-1:0] cnt_in;

    // Machine-cycle count as seen by the sequencer: 0 means 1, anything above 5 means 5
    always_comb begin
        if (inMC == 3'd0) begin
            cnt_in = MC_W'(1);
        end else if (inMC > 3'(MC_MAX)) begin
            cnt_in = MC_W'(MC_MAX);
        end else begin
            cnt_in = inMC;
        end
    end

    // Next-state logic plus decode of the next outputs, so outputs come straight from flops
    always_comb begin
        state_d  = state_q;
        mc_d     = mc_q;
        cnt_d    = cnt_q;
        six_d    = six_q;
        halted_d = halted_q;
        hpend_d  = hpend_q;
        end_mc   = 1'b0;

        unique case (state_q)
            ST_T1: state_d = ST_T2;
            ST_T2, ST_TW: state_d = inRDY ? ST_T3 : ST_TW;
            ST_T3: begin
                if (mc_q == MC_W'(1)) begin
                    cnt_d   = cnt_in;
                    six_d   = inT6;
                    hpend_d = inHLT;
                    state_d = ST_T4;
                end else begin
                    end_mc = 1'b1;
                end
            end
            ST_T4: begin
                if (six_q) begin
                    state_d = ST_T5;
                end else begin
                    end_mc = 1'b1;
                end
            end
            ST_T5: state_d = ST_T6;
            ST_T6: end_mc = 1'b1;
            ST_THLD: begin
                if (!inHLD) begin
                    state_d = halted_q ? ST_THLT : ST_T1;
                end
            end
            ST_THLT: begin
                if (inHLD) begin
                    state_d = ST_THLD;
                end
            end
            default: state_d = ST_T1;
        endcase

        if (end_mc) begin
            if (mc_q == cnt_q) begin
                mc_d = MC_W'(1);
                if (hpend_q) begin
                    halted_d = 1'b1;
                    hpend_d  = 1'b0;
                    state_d  = ST_THLT;
                end else begin
                    state_d = ST_T1;
                end
            end else begin
                mc_d    = mc_q + MC_W'(1);
                state_d = ST_T1;
            end
            // HOLD is granted only here, between machine cycles; pending mc is kept
            if (inHLD) begin
                state_d = ST_THLD;
            end
        end

        unique case (state_d)
            ST_T1:   t_d = 3'd1;
            ST_T2:   t_d = 3'd2;
            ST_T3:   t_d = 3'd3;
            ST_T4:   t_d = 3'd4;
            ST_T5:   t_d = 3'd5;
            ST_T6:   t_d = 3'd6;
            ST_TW:   t_d = 3'd7;
            default: t_d = 3'd0;
        endcase

        end_state = ((state_d == ST_T3) && (mc_d != MC_W'(1))) ||
                    ((state_d == ST_T4) && !six_d) ||
                    (state_d == ST_T6);

        m_d    = (state_d == ST_THLT) ? 3'd1 : 3'(mc_d);
        ale_d  = (state_d == ST_T1);
        fet_d  = (mc_d == MC_W'(1)) && (state_d != ST_THLT) && (state_d != ST_THLD);
        lst_d  = end_state && (mc_d == cnt_d);
        hlda_d = (state_d == ST_THLD);
        hlt_d  = (state_d == ST_THLT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_T1;
            mc_q     <= MC_W'(1);
            cnt_q    <= MC_W'(1);
            six_q    <= 1'b0;
            halted_q <= 1'b0;
            hpend_q  <= 1'b0;
            t_q      <= 3'd1;
            m_q      <= 3'd1;
            ale_q    <= 1'b1;
            fet_q    <= 1'b1;
            lst_q    <= 1'b0;
            hlda_q   <= 1'b0;
            hlt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mc_q     <= mc_d;
            cnt_q    <= cnt_d;
            six_q    <= six_d;
            halted_q <= halted_d;
            hpend_q  <= hpend_d;
            t_q      <= t_d;
            m_q      <= m_d;
            ale_q    <= ale_d;
            fet_q    <= fet_d;
            lst_q    <= lst_d;
            hlda_q   <= hlda_d;
            hlt_q    <= hlt_d;
        end
    end

    assign outT    = t_q;
    assign outM    = m_q;
    assign outALE  = ale_q;
    assign outFET  = fet_q;
    assign outLST  = lst_q;
    assign outHLDA = hlda_q;
    assign outHLT  = hlt_q;

endmodule

// File: tb/tb_mcycle85.sv
// Bench for mcycle85: per-clock vector table with expected outputs queued as each
// vector is driven and popped after the clock edge.
`timescale 1ns/1ps

module tb_mcycle85;

    logic       clk = 1'b0;
    logic       rst;
    logic       inRDY, inHLD, inT6, inHLT;
    logic [2:0] inMC;
    logic [2:0] outT, outM;
    logic       outALE, outFET, outLST, outHLDA, outHLT;

    mcycle85 dut (
        .clk(clk), .rst(rst),
        .inRDY(inRDY), .inHLD(inHLD), .inMC(inMC), .inT6(inT6), .inHLT(inHLT),
        .outT(outT), .outM(outM), .outALE(outALE), .outFET(outFET),
        .outLST(outLST), .outHLDA(outHLDA), .outHLT(outHLT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mc;
        logic       t6, hlt, rdy, hld;
        logic [2:0] et, em;
        logic       lst, hlda, h;
    } vec_t;

    typedef struct packed {
        logic [2:0] t;
        logic [2:0] m;
        logic       ale, fet, lst, hlda, hlt;
    } obs_t;

    localparam obs_t RST_OBS = '{t: 3'd1, m: 3'd1, ale: 1'b1, fet: 1'b1,
                                 lst: 1'b0, hlda: 1'b0, hlt: 1'b0};

    vec_t tbl[$];
    obs_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [2:0] cur_mc;
    logic       cur_t6, cur_hlt, cur_rdy, cur_hld;

    // Append one clock of stimulus (current cur_* inputs) with the outputs expected after it
    task automatic s(input logic [2:0] et, input logic [2:0] em, input logic [2:0] flags);
        vec_t v;
        v.mc = cur_mc; v.t6 = cur_t6; v.hlt = cur_hlt; v.rdy = cur_rdy; v.hld = cur_hld;
        v.et = et; v.em = em; v.lst = flags[2]; v.hlda = flags[1]; v.h = flags[0];
        tbl.push_back(v);
    endtask

    function automatic obs_t expect_of(input vec_t v);
        obs_t o;
        o.t = v.et; o.m = v.em;
        o.ale = (v.et == 3'd1);
        o.fet = (v.em == 3'd1) && (v.et != 3'd0);
        o.lst = v.lst; o.hlda = v.hlda; o.hlt = v.h;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = '{t: outT, m: outM, ale: outALE, fet: outFET, lst: outLST,
                hlda: outHLDA, hlt: outHLT};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got T=%0d M=%0d ALE=%0b FET=%0b LST=%0b HLDA=%0b HLT=%0b, expected T=%0d M=%0d ALE=%0b FET=%0b LST=%0b HLDA=%0b HLT=%0b",
                     name, act.t, act.m, act.ale, act.fet, act.lst, act.hlda, act.hlt,
                     exp.t, exp.m, exp.ale, exp.fet, exp.lst, exp.hlda, exp.hlt);
        end
    endtask

    task automatic run_steps(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            inMC = tbl[i].mc; inT6 = tbl[i].t6; inHLT = tbl[i].hlt;
            inRDY = tbl[i].rdy; inHLD = tbl[i].hld;
            sb_q.push_back(expect_of(tbl[i]));
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_empty: step %0d has no expected entry", i);
            end else begin
                check($sformatf("step%0d", i), sb_q.pop_front());
            end
        end
    endtask

    int seg1_end;

    initial begin
        cur_mc = 3'd1; cur_t6 = 1'b0; cur_hlt = 1'b0; cur_rdy = 1'b1; cur_hld = 1'b0;

        // 4-T single-cycle instructions
        repeat (2) begin
            s(2,1,3'b000); s(3,1,3'b000); s(4,1,3'b100); s(1,1,3'b000);
        end
        // 3 machine cycles, 6-T M1
        cur_mc = 3'd3; cur_t6 = 1'b1;
        s(2,1,3'b000); s(3,1,3'b000); s(4,1,3'b000); s(5,1,3'b000); s(6,1,3'b000);
        s(1,2,3'b000); s(2,2,3'b000); s(3,2,3'b000);
        s(1,3,3'b000); s(2,3,3'b000); s(3,3,3'b100); s(1,1,3'b000);
        // Two waits in M2; READY low in T1 and T3 of M1 is ignored
        cur_mc = 3'd2; cur_t6 = 1'b0;
        cur_rdy = 1'b0; s(2,1,3'b000);
        cur_rdy = 1'b1; s(3,1,3'b000);
        cur_rdy = 1'b0; s(4,1,3'b000);
        cur_rdy = 1'b1; s(1,2,3'b000); s(2,2,3'b000);
        cur_rdy = 1'b0; s(7,2,3'b000); s(7,2,3'b000);
        cur_rdy = 1'b1; s(3,2,3'b100); s(1,1,3'b000);
        // HOLD between M1 and M2; HOLD in T1 is ignored
        s(2,1,3'b000); s(3,1,3'b000); s(4,1,3'b000);
        cur_hld = 1'b1; s(0,2,3'b010); s(0,2,3'b010);
        cur_hld = 1'b0; s(1,2,3'b000);
        cur_hld = 1'b1; s(2,2,3'b000);
        cur_hld = 1'b0; s(3,2,3'b100); s(1,1,3'b000);
        // inMC = 0 behaves as one cycle
        cur_mc = 3'd0;
        s(2,1,3'b000); s(3,1,3'b000); s(4,1,3'b100); s(1,1,3'b000);
        // inMC = 7 behaves as five cycles
        cur_mc = 3'd7;
        s(2,1,3'b000); s(3,1,3'b000); s(4,1,3'b000);
        s(1,2,3'b000); s(2,2,3'b000); s(3,2,3'b000);
        s(1,3,3'b000); s(2,3,3'b000); s(3,3,3'b000);
        s(1,4,3'b000); s(2,4,3'b000); s(3,4,3'b000);
        s(1,5,3'b000); s(2,5,3'b000); s(3,5,3'b100); s(1,1,3'b000);
        // HLT, then a HOLD pulse while halted
        cur_mc = 3'd1; cur_hlt = 1'b1;
        s(2,1,3'b000); s(3,1,3'b000); s(4,1,3'b100);
        cur_hlt = 1'b0; s(0,1,3'b001); s(0,1,3'b001);
        cur_hld = 1'b1; s(0,1,3'b010); s(0,1,3'b010);
        cur_hld = 1'b0; s(0,1,3'b001);
        seg1_end = tbl.size();

        // After reset: HLT ending together with HOLD goes to hold first, then halt
        cur_hlt = 1'b1;
        s(2,1,3'b000);
        cur_hld = 1'b1; s(3,1,3'b000);
        cur_hld = 1'b0; s(4,1,3'b100);
        cur_hlt = 1'b0;
        cur_hld = 1'b1; s(0,1,3'b010); s(0,1,3'b010);
        cur_hld = 1'b0; s(0,1,3'b001); s(0,1,3'b001);

        rst = 1'b1;
        inRDY = 1'b1; inHLD = 1'b0; inMC = 3'd1; inT6 = 1'b0; inHLT = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", RST_OBS);
        rst = 1'b0;
        #1;
        check("reset_release", RST_OBS);

        run_steps(0, seg1_end - 1);

        // Asynchronous reset from halt, away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_halt", RST_OBS);
        @(posedge clk);
        #1;
        check("rst_held", RST_OBS);
        rst = 1'b0;

        run_steps(seg1_end, tbl.size() - 1);

        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
